multicycle_control: RTL and testbench

//   Multi-cycle control FSM for the RV32I-subset datapath. It fetches and decodes each

---
 rtl/multicycle_control.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle control FSM for an RV32I-subset datapath.
//               It fetches and decodes each instruction, drives the ALU
//               operation and operand selects, and sequences the register,
//               memory and PC writes. It uses the ALU zero flag to resolve
//               beq.
// Ports       : clk, rst (async, active-high)
//               instr       - memory read data in FETCH, IR contents after
//               mem_ready   - memory access completes this cycle
//               zero        - ALU result == 0
//               alu_control - 000 add, 001 or, 010 and, 011 sll, 100 sub
//               alu_src_a   - 0 PC, 1 rs1, 2 old PC
//               alu_src_b   - 0 rs2, 1 immediate, 2 constant 4
//               pc_write, pc_src, ir_write, mem_read, mem_write, iord,
//               reg_write, mem_to_reg - datapath strobes and selects
//               halted      - illegal instruction seen, FSM parked
//               retired     - instructions completed since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             zero,
  output logic [2:0]       alu_control,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_EXEC_R    = 4'd2;
  localparam logic [3:0] S_EXEC_I    = 4'd3;
  localparam logic [3:0] S_ALU_WB    = 4'd4;
  localparam logic [3:0] S_MEM_ADDR  = 4'd5;
  localparam logic [3:0] S_MEM_READ  = 4'd6;
  localparam logic [3:0] S_MEM_WB    = 4'd7;
  localparam logic [3:0] S_MEM_WRITE = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_ILLEGAL   = 4'd10;

  localparam logic [6:0] C_OP_R      = 7'b0110011;
  localparam logic [6:0] C_OP_I      = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;

  localparam logic [2:0] C_ALU_ADD   = 3'b000;
  localparam logic [2:0] C_ALU_OR    = 3'b001;
  localparam logic [2:0] C_ALU_AND   = 3'b010;
  localparam logic [2:0] C_ALU_SLL   = 3'b011;
  localparam logic [2:0] C_ALU_SUB   = 3'b100;

  localparam logic [6:0] C_F7_ZERO   = 7'b0000000;
  localparam logic [6:0] C_F7_ALT    = 7'b0100000;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_r_ok;
  logic [2:0] w_r_op;
  logic       w_i_ok;
  logic [2:0] w_i_op;
  logic       w_beq_ok;
  logic       w_retire;
  logic       w_unused;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  // Register and immediate fields are consumed by the datapath, not here.
  assign w_unused = ^{instr[24:15], instr[11:7]};

  assign w_beq_ok = (w_funct3 == 3'b000);

  // R-type operation decode; w_r_ok low routes the FSM to ILLEGAL.
  always_comb begin
    w_r_ok = 1'b1;
    w_r_op = C_ALU_ADD;
    case (w_funct3)
      3'b000: begin
        if (w_funct7 == C_F7_ALT)       w_r_op = C_ALU_SUB;
        else if (w_funct7 != C_F7_ZERO) w_r_ok = 1'b0;
      end
      3'b110:  begin w_r_op = C_ALU_OR;  w_r_ok = (w_funct7 == C_F7_ZERO); end
      3'b111:  begin w_r_op = C_ALU_AND; w_r_ok = (w_funct7 == C_F7_ZERO); end
      3'b001:  begin w_r_op = C_ALU_SLL; w_r_ok = (w_funct7 == C_F7_ZERO); end
      default: w_r_ok = 1'b0;
    endcase
  end

  // I-type decode; only the shift constrains funct7 (upper imm bits).
  always_comb begin
    w_i_ok = 1'b1;
    w_i_op = C_ALU_ADD;
    case (w_funct3)
      3'b000:  w_i_op = C_ALU_ADD;
      3'b110:  w_i_op = C_ALU_OR;
      3'b111:  w_i_op = C_ALU_AND;
      3'b001:  begin w_i_op = C_ALU_SLL; w_i_ok = (w_funct7 == C_F7_ZERO); end
      default: w_i_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          C_OP_R:                w_next = S_EXEC_R;
          C_OP_I:                w_next = S_EXEC_I;
          C_OP_LOAD, C_OP_STORE: w_next = S_MEM_ADDR;
          C_OP_BRANCH:           w_next = S_BRANCH;
          default:               w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:    w_next = w_r_ok ? S_ALU_WB : S_ILLEGAL;
      S_EXEC_I:    w_next = w_i_ok ? S_ALU_WB : S_ILLEGAL;
      S_ALU_WB:    w_next = S_FETCH;
      S_MEM_ADDR: begin
        if (w_funct3 != 3'b010)         w_next = S_ILLEGAL;
        else if (w_opcode == C_OP_LOAD) w_next = S_MEM_READ;
        else                            w_next = S_MEM_WRITE;
      end
      S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
      S_BRANCH:    w_next = w_beq_ok ? S_FETCH : S_ILLEGAL;
      S_ILLEGAL:   w_next = S_ILLEGAL;
      default:     w_next = S_FETCH;
    endcase
  end

  // Final cycle of every legal instruction.
  assign w_retire = (r_state == S_ALU_WB) || (r_state == S_MEM_WB) ||
                    ((r_state == S_MEM_WRITE) && mem_ready) ||
                    ((r_state == S_BRANCH) && w_beq_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    alu_control = C_ALU_ADD;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd2;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'd1;
        alu_control = w_r_ok ? w_r_op : C_ALU_ADD;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'd1;
        alu_src_b   = 2'd1;
        alu_control = w_i_ok ? w_i_op : C_ALU_ADD;
      end
      S_ALU_WB:    reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 2'd1;
        alu_control = C_ALU_SUB;
        pc_src      = 1'b1;
        pc_write    = zero && w_beq_ok;
      end
      S_ILLEGAL:   halted = 1'b1;
      default: ;
    endcase
    // The state register already sits in FETCH while rst is high; the
    // strobes are silenced so a held reset never issues a memory request.
    if (rst) begin
      alu_control = C_ALU_ADD;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      ir_write    = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Instruction
//               vectors list the expected phase of every cycle; each cycle's
//               expected output bundle is queued when driven and compared
//               on the following falling edge. A narrow counter exercises
//               the retired-count wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam int TB_CNT_W = 3;

  localparam logic [3:0] P_F   = 4'd1;   // fetch, memory ready
  localparam logic [3:0] P_FW  = 4'd2;   // fetch, waiting
  localparam logic [3:0] P_D   = 4'd3;
  localparam logic [3:0] P_X   = 4'd4;   // EXEC_R / EXEC_I
  localparam logic [3:0] P_WB  = 4'd5;
  localparam logic [3:0] P_MA  = 4'd6;
  localparam logic [3:0] P_MR  = 4'd7;
  localparam logic [3:0] P_MRW = 4'd8;
  localparam logic [3:0] P_MWB = 4'd9;
  localparam logic [3:0] P_MW  = 4'd10;
  localparam logic [3:0] P_MWW = 4'd11;
  localparam logic [3:0] P_BR  = 4'd12;
  localparam logic [3:0] P_ILL = 4'd13;

  logic                clk;
  logic                rst;
  logic [31:0]         instr;
  logic                mem_ready;
  logic                zero;
  logic [2:0]          alu_control;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic                pc_write;
  logic                pc_src;
  logic                ir_write;
  logic                mem_read;
  logic                mem_write;
  logic                iord;
  logic                reg_write;
  logic                mem_to_reg;
  logic                halted;
  logic [TB_CNT_W-1:0] retired;

  multicycle_control #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted),
    .retired(retired)
  );

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic [2:0]  op;     // expected alu_control in the execute phase
    logic [1:0]  srcb;   // expected alu_src_b in the execute phase
    logic        ret;    // instruction retires
    int          len;
    logic [39:0] ph;     // phase per cycle, first phase in the top nibble
  } vec_t;

  typedef struct {
    logic [15:0]         bundle;
    logic [TB_CNT_W-1:0] ret;
    int                  ph;
  } exp_t;

  exp_t                sb[$];
  vec_t                tbl[12];
  logic [TB_CNT_W-1:0] exp_ret;
  int                  n_checks;
  int                  n_err;
  logic [15:0]         act_bundle;
  logic [8:0]          act_strobes;

  assign act_bundle  = {alu_control, alu_src_a, alu_src_b, pc_write, pc_src,
                        ir_write, mem_read, mem_write, iord, reg_write,
                        mem_to_reg, halted};
  assign act_strobes = act_bundle[8:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_bundle(input logic [3:0] ph, input logic [2:0] op,
                                             input logic [1:0] srcb, input logic z);
    logic [2:0] o;
    logic [1:0] a, b;
    logic pcw, pcs, irw, mr, mw, io, rw, m2r, h;
    o = 3'b000; a = 2'd0; b = 2'd0;
    pcw = 0; pcs = 0; irw = 0; mr = 0; mw = 0; io = 0; rw = 0; m2r = 0; h = 0;
    case (ph)
      P_F:         begin b = 2'd2; pcw = 1; irw = 1; mr = 1; end
      P_FW:        begin b = 2'd2; mr = 1; end
      P_D:         begin a = 2'd2; b = 2'd1; end
      P_X:         begin o = op; a = 2'd1; b = srcb; end
      P_WB:        rw = 1;
      P_MA:        begin a = 2'd1; b = 2'd1; end
      P_MR, P_MRW: begin mr = 1; io = 1; end
      P_MWB:       begin rw = 1; m2r = 1; end
      P_MW, P_MWW: begin mw = 1; io = 1; end
      P_BR:        begin o = 3'b100; a = 2'd1; pcs = 1; pcw = z; end
      P_ILL:       h = 1;
      default: ;
    endcase
    return {o, a, b, pcw, pcs, irw, mr, mw, io, rw, m2r, h};
  endfunction

  // Scoreboard consumer: one queued expectation per driven cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("outputs phase%0d", e.ph), {16'h0, act_bundle}, {16'h0, e.bundle});
      chk($sformatf("retired phase%0d", e.ph), {29'h0, retired}, {29'h0, e.ret});
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t       e;
    logic [3:0] p;
    for (int i = 0; i < v.len; i++) begin
      p = v.ph[39-4*i -: 4];
      @(posedge clk); #1;
      instr     = v.instr;
      zero      = v.zero;
      mem_ready = !(p == P_FW || p == P_MRW || p == P_MWW);
      e.bundle  = exp_bundle(p, v.op, v.srcb, v.zero);
      e.ret     = exp_ret;
      e.ph      = p;
      sb.push_back(e);
    end
    if (v.ret) exp_ret = exp_ret + {{(TB_CNT_W-1){1'b0}}, 1'b1};
  endtask

  // Park check, then reset and confirm the FSM restarts in FETCH.
  task automatic halt_and_reset(input logic [TB_CNT_W-1:0] ret_before);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1;
    chk("halted_stays", {31'h0, halted}, 32'h1);
    chk("halted_retired_frozen", {29'h0, retired}, {29'h0, ret_before});
    rst = 1'b1;
    #1;
    chk("halt_reset_strobes", {23'h0, act_strobes}, 32'h0);
    chk("halt_reset_retired", {29'h0, retired}, 32'h0);
    exp_ret = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t part, ill1, ill2;
    n_checks = 0;
    n_err    = 0;
    exp_ret  = '0;
    rst = 1'b1; instr = 32'h0; mem_ready = 1'b0; zero = 1'b0;

    //           instr         zero  op      srcb  ret   len  phases
    tbl[0]  = '{32'h002081B3, 1'b0, 3'b000, 2'd0, 1'b1, 4, {P_F, P_D, P_X, P_WB, 24'h0}};
    tbl[1]  = '{32'h40208233, 1'b0, 3'b100, 2'd0, 1'b1, 4, {P_F, P_D, P_X, P_WB, 24'h0}};
    tbl[2]  = '{32'h00209293, 1'b0, 3'b011, 2'd1, 1'b1, 4, {P_F, P_D, P_X, P_WB, 24'h0}};
    tbl[3]  = '{32'h0020E1B3, 1'b0, 3'b001, 2'd0, 1'b1, 4, {P_F, P_D, P_X, P_WB, 24'h0}};
    tbl[4]  = '{32'h0FF0F093, 1'b0, 3'b010, 2'd1, 1'b1, 4, {P_F, P_D, P_X, P_WB, 24'h0}};
    tbl[5]  = '{32'h00500093, 1'b0, 3'b000, 2'd1, 1'b1, 6, {P_FW, P_FW, P_F, P_D, P_X, P_WB, 16'h0}};
    tbl[6]  = '{32'h00208463, 1'b1, 3'b000, 2'd0, 1'b1, 3, {P_F, P_D, P_BR, 28'h0}};
    tbl[7]  = '{32'h00208463, 1'b0, 3'b000, 2'd0, 1'b1, 3, {P_F, P_D, P_BR, 28'h0}};
    tbl[8]  = '{32'h0000A183, 1'b0, 3'b000, 2'd0, 1'b1, 8,
                {P_F, P_D, P_MA, P_MRW, P_MRW, P_MRW, P_MR, P_MWB, 8'h0}};
    tbl[9]  = '{32'h0000A183, 1'b0, 3'b000, 2'd0, 1'b1, 5, {P_F, P_D, P_MA, P_MR, P_MWB, 20'h0}};
    tbl[10] = '{32'h0020A223, 1'b0, 3'b000, 2'd0, 1'b1, 4, {P_F, P_D, P_MA, P_MW, 24'h0}};
    tbl[11] = '{32'h0020A223, 1'b0, 3'b000, 2'd0, 1'b1, 6,
                {P_F, P_D, P_MA, P_MWW, P_MWW, P_MW, 16'h0}};
    part = '{32'h0000A183, 1'b0, 3'b000, 2'd0, 1'b0, 4, {P_F, P_D, P_MA, P_MRW, 24'h0}};
    ill1 = '{32'hFFFFFFFF, 1'b0, 3'b000, 2'd0, 1'b0, 6,
             {P_F, P_D, P_ILL, P_ILL, P_ILL, P_ILL, 16'h0}};
    ill2 = '{32'h0000B183, 1'b0, 3'b000, 2'd0, 1'b0, 5, {P_F, P_D, P_MA, P_ILL, P_ILL, 20'h0}};

    #2;
    chk("reset_strobes", {23'h0, act_strobes}, 32'h0);
    chk("reset_alu_control", {29'h0, alu_control}, 32'h0);
    chk("reset_retired", {29'h0, retired}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Twelve legal instructions also carry the 3-bit counter through a wrap.
    for (int k = 0; k < 12; k++) run_vec(tbl[k]);

    // Asynchronous reset while a load waits for memory.
    run_vec(part);
    @(posedge clk); #1;
    chk("mem_read_held_in_wait", {30'h0, mem_read, iord}, 32'h3);
    rst = 1'b1;
    #1;
    chk("midload_reset_strobes", {23'h0, act_strobes}, 32'h0);
    chk("midload_reset_retired", {29'h0, retired}, 32'h0);
    chk("midload_reset_halted", {31'h0, halted}, 32'h0);
    exp_ret = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("fetch_after_reset", {27'h0, mem_read, iord, mem_write, alu_src_b}, {27'h0, 5'b10010});

    // Illegal opcode, then illegal load width; each parks until reset.
    run_vec(tbl[0]);
    run_vec(ill1);
    halt_and_reset(3'd1);
    run_vec(tbl[1]);
    run_vec(tbl[6]);
    run_vec(ill2);
    halt_and_reset(3'd2);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
